// File: rtl/shift_seq_unit.sv
// shift_seq_unit: multicycle shifter that moves the latched operand one bit
// per clock (SLL/SRL/SRA/ROR) under a Start/Busy/Done handshake. The result
// register holds its value until the next accepted Start.
module shift_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       ShiftOp,
    input  logic [WIDTH-1:0] DataIn,
    input  logic [AMT_W-1:0] ShiftAmtIn,
    output logic [WIDTH-1:0] DataOut,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shifted;

    // One-position shift of the current result according to the latched op
    always_comb begin
        shifted = data_q;
        unique case (op_q)
            OP_SLL: shifted = {data_q[WIDTH-2:0], 1'b0};
            OP_SRL: shifted = {1'b0, data_q[WIDTH-1:1]};
            OP_SRA: shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_ROR: shifted = {data_q[0], data_q[WIDTH-1:1]};
            default: shifted = data_q;
        endcase
    end

    // Next-state, operand latch and down-counter; Start is only honoured in IDLE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    data_d  = DataIn;
                    op_d    = op_t'(ShiftOp);
                    cnt_d   = ShiftAmtIn;
                    state_d = (ShiftAmtIn == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = shifted;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs are decoded purely from the state register
    always_comb begin
        DataOut = data_q;
        Busy    = (state_q != IDLE);
        Done    = (state_q == DONE);
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: a driver pushes expected result and
// Done cycle into a scoreboard; a monitor pops and compares on every Done.
module tb_shift_seq_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AMT_W = 5;

    logic             clk;
    logic             reset;
    logic             Start;
    logic [1:0]       ShiftOp;
    logic [WIDTH-1:0] DataIn;
    logic [AMT_W-1:0] ShiftAmtIn;
    logic [WIDTH-1:0] DataOut;
    logic             Busy;
    logic             Done;

    typedef struct {
        logic [WIDTH-1:0] data;
        int unsigned      cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned checks;
    int unsigned errors;
    int unsigned dones_seen;
    int unsigned dones_expected;

    shift_seq_unit #(
        .WIDTH(WIDTH),
        .AMT_W(AMT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .ShiftOp    (ShiftOp),
        .DataIn     (DataIn),
        .ShiftAmtIn (ShiftAmtIn),
        .DataOut    (DataOut),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc is the index of the current cycle; it advances at each rising edge
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference result built from native operators rather than bit-serial steps
    function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                               input int unsigned amt);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = d << amt;
            2'b01:   r = d >> amt;
            2'b10:   r = $unsigned($signed(d) >>> amt);
            default: r = (amt == 0) ? d : ((d >> amt) | (d << (WIDTH - amt)));
        endcase
        return r;
    endfunction

    task automatic push_exp(input logic [WIDTH-1:0] data, input int unsigned done_cyc);
        exp_t e;
        e.data = data;
        e.cyc  = done_cyc;
        sb.push_back(e);
        dones_expected++;
    endtask

    // Scoreboard monitor: every Done must match the oldest outstanding operation
    always @(negedge clk) begin
        if (reset && Done) begin
            dones_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(Done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_data", DataOut, e.data);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // One complete operation with Busy/Done profile and result-hold checks
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] d, input int unsigned amt);
        int unsigned      c;
        logic [WIDTH-1:0] r;
        @(negedge clk);
        r          = model(op, d, amt);
        Start      = 1'b1;
        ShiftOp    = op;
        DataIn     = d;
        ShiftAmtIn = AMT_W'(amt);
        c          = cyc;
        push_exp(r, c + 1 + amt);
        @(negedge clk);
        // Operands change after the Start edge; the latched copy must be used
        Start      = 1'b0;
        ShiftOp    = 2'($urandom);
        DataIn     = $urandom;
        ShiftAmtIn = AMT_W'($urandom);
        for (int unsigned i = 0; i <= amt; i++) begin
            check("busy_high", 32'(Busy), 32'd1);
            if (i < amt) check("done_low_early", 32'(Done), 32'd0);
            @(negedge clk);
        end
        check("busy_after", 32'(Busy), 32'd0);
        check("done_after", 32'(Done), 32'd0);
        check("idle_hold", DataOut, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] r;
        int unsigned      c;
        checks         = 0;
        errors         = 0;
        dones_seen     = 0;
        dones_expected = 0;
        reset      = 1'b0;
        Start      = 1'b0;
        ShiftOp    = 2'b00;
        DataIn     = '0;
        ShiftAmtIn = '0;
        repeat (3) @(negedge clk);
        check("rst_dataout", DataOut, 32'h0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(2'b00, 32'h0000_0001, 4);
        run_op(2'b10, 32'h8000_0000, 31);
        run_op(2'b01, 32'h8000_0000, 31);
        run_op(2'b00, 32'hDEAD_BEEF, 0);
        run_op(2'b11, 32'h0000_0003, 1);
        check("ror_const", DataOut, 32'h8000_0001);

        // Start pulses while busy must be ignored
        @(negedge clk);
        r = model(2'b11, 32'h0000_0003, 1);
        Start = 1'b1; ShiftOp = 2'b11; DataIn = 32'h0000_0003; ShiftAmtIn = 5'd1;
        c = cyc;
        push_exp(r, c + 2);
        @(negedge clk);
        Start = 1'b1; ShiftOp = 2'b00; DataIn = 32'h1234_5678; ShiftAmtIn = 5'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (4) @(negedge clk);
        check("ignore_result", DataOut, 32'h8000_0001);
        check("ignore_busy", 32'(Busy), 32'd0);

        // Longer shift with a burst of Start pulses mid-operation
        @(negedge clk);
        Start = 1'b1; ShiftOp = 2'b00; DataIn = 32'h0000_0001; ShiftAmtIn = 5'd8;
        c = cyc;
        push_exp(32'h0000_0100, c + 9);
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        Start = 1'b1; ShiftOp = 2'b01; DataIn = 32'hFFFF_FFFF; ShiftAmtIn = 5'd2;
        repeat (2) @(negedge clk);
        Start = 1'b0;
        repeat (8) @(negedge clk);
        check("burst_result", DataOut, 32'h0000_0100);

        // Asynchronous reset in the middle of an SLL by 8
        @(negedge clk);
        Start = 1'b1; ShiftOp = 2'b00; DataIn = 32'h0000_0001; ShiftAmtIn = 5'd8;
        c = cyc;
        @(negedge clk);
        Start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", 32'(Busy), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_dataout", DataOut, 32'h0);
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_done", 32'(Done), 32'd0);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(Busy), 32'd0);
        run_op(2'b01, 32'h0000_0100, 8);
        check("srl_after_rst", DataOut, 32'h0000_0001);

        // Start held high: second op latched in the first IDLE cycle after Done
        @(negedge clk);
        Start = 1'b1; ShiftOp = 2'b00; DataIn = 32'h0000_0001; ShiftAmtIn = 5'd2;
        c = cyc;
        push_exp(32'h0000_0004, c + 3);
        push_exp(32'h0000_0004, c + 7);
        repeat (5) @(negedge clk);
        Start = 1'b0;
        repeat (6) @(negedge clk);
        check("b2b_idle", 32'(Busy), 32'd0);

        // Random operations
        for (int unsigned k = 0; k < 8; k++) begin
            run_op(2'($urandom), $urandom, $urandom_range(0, WIDTH - 1));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        check("done_count", dones_seen, dones_expected);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_seq_unit.md
# shift_seq_unit

Multicycle barrel-free shifter for the InfraHard MIPS datapath. It consumes the 5-bit shift amount produced by the shift-amount select stage (RegB[4:0], Shamt or extended offset). It shifts the latched operand one bit per clock under a Start/Busy/Done handshake with the control unit. It implements sll/srl/sra and their variable forms, plus rotate-right, with a result register held until the next Start.

## Interface
- WIDTH, 32, operand/result width
- AMT_W, 5, shift-amount width (covers 0..WIDTH-1)

- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- Start  in  1  load request; sampled only in IDLE
- ShiftOp  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; latched with Start
- DataIn  in  WIDTH  operand; latched with Start
- ShiftAmtIn  in  AMT_W  shift amount; latched with Start
- DataOut  out  WIDTH  result register
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle pulse; DataOut valid

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE with Start=1 at a clock edge:
  - latch DataIn into DataOut, ShiftOp into op register, ShiftAmtIn into down-counter Cnt.
  - ShiftAmtIn=0 -> DONE; otherwise -> SHIFT.
- IDLE with Start=0: hold everything; DataOut keeps the last result.
- SHIFT, every edge: shift DataOut one position per op, Cnt <= Cnt-1; if Cnt==1 -> DONE, else stay.
- Per-bit operations:
  - SLL: {D[WIDTH-2:0],0}
  - SRL: {0,D[WIDTH-1:1]}
  - SRA: {D[WIDTH-1],D[WIDTH-1:1]}
  - ROR: {D[0],D[WIDTH-1:1]}
- DONE: Done=1 for exactly this cycle; next edge -> IDLE unconditionally.
- Start while Busy (SHIFT or DONE) is ignored: no re-latch, no effect on Cnt. The control unit must wait for Done.
- Op, amount and DataIn changes after the Start edge have no effect (all are latched).
- Amount range: 0..WIDTH-1 only; the upper bits of a wider source are already truncated upstream. No modulo logic is needed.
- Reset (any time, including mid-SHIFT): state=IDLE, DataOut=0, Cnt=0, op=00, Busy=0, Done=0, asynchronously. The first Start after reset release behaves normally.

## Timing
- Start sampled at the edge ending cycle c.
- Busy=1 from cycle c+1 through cycle c+1+N, where N = ShiftAmtIn.
- Done=1 only in cycle c+1+N. Latency is N+1 cycles; N=0 gives Done in c+1 with DataOut=DataIn.
- DataOut changes every SHIFT cycle (intermediate values). Consumers may sample it only when Done=1 or in IDLE after a Done.
- A new Start is accepted in cycle c+2+N at the earliest (first IDLE cycle). Throughput is one operation per N+2 cycles.
- Outputs are registered: no combinational path from inputs to DataOut/Busy/Done.
- Reset values: DataOut=0x00000000, Busy=0, Done=0.

## Test plan
- SLL 0x00000001 by 4, Start in cycle 0 -> Busy cycles 1-5, Done in cycle 5, DataOut=0x00000010.
- SRA 0x80000000 by 31 -> Done in cycle 32, DataOut=0xFFFFFFFF; the same operand with SRL -> 0x00000001.
- Amount 0, SLL on 0xDEADBEEF -> Done in cycle 1, DataOut=0xDEADBEEF, Busy high only in cycle 1.
- ROR 0x00000003 by 1 -> 0x80000001 at Done. Pulse Start with other operands during SHIFT -> ignored, result unchanged, single Done.
- Assert reset during cycle 3 of an SLL-by-8 -> DataOut=0, Busy=0, Done=0 immediately, no Done later. After release, Start SRL 0x100 by 8 -> 0x00000001 with Done in cycle 9 relative to that Start.
- Back-to-back: Start asserted continuously for SLL 0x1 by 2 -> second operation latched in the first IDLE cycle after Done, and exactly one Done per operation.
